seq_slice_adder: RTL

//   Parametrised multi-cycle add/subtract unit. Adds two WIDTH-bit operands CHUNK bits per clock

---
 rtl/adder_pkg.sv | 21 ++
 rtl/seq_slice_adder_rca_slice.sv | 37 +++
 rtl/seq_slice_adder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pkg
//  Purpose  : Shared definitions for the sequential slice adder.
//             - FSM state encoding (2-bit): S_IDLE, S_RUN, S_DONE
//             - Operation mode constants: MODE_ADD, MODE_SUB
//  Revision : 1.0  initial release
// ============================================================================
package adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/seq_slice_adder_rca_slice.sv
`default_nettype none
// ============================================================================
//  Module   : rca_slice
//  Purpose  : Combinational CHUNK-bit ripple-carry adder slice.
//  Ports    : a, b   [CHUNK-1:0]  slice operands
//             ci                  carry into the slice LSB
//             s      [CHUNK-1:0]  slice sum
//             co                  carry out of the slice MSB
//             c_msb               carry into the slice MSB (overflow detection)
//  Revision : 1.0  initial release
// ============================================================================
module rca_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   // c[i] is the carry into bit i; c[CHUNK] is the slice carry-out.
   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule : rca_slice
`default_nettype wire

// File: rtl/seq_slice_adder.sv
`default_nettype none
// ============================================================================
//  Module   : seq_slice_adder
//  Purpose  : Multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through
//             one shared ripple-carry slice; carry held in a register.
//  Ports    : clk, rst (sync, active-high)
//             start, sub, a, b, cin   request, mode and operands
//             busy                    high while operating
//             done                    one-cycle result-valid pulse
//             sum, cout, ovf          result and flags
//  Revision : 1.0  initial release
// ============================================================================
module seq_slice_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("seq_slice_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;       // already inverted in subtract mode
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] sl_a, sl_b, sl_s;
   logic             sl_co, sl_cmsb;

   rca_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (sl_a),
      .b     (sl_b),
      .ci    (carry_q),
      .s     (sl_s),
      .co    (sl_co),
      .c_msb (sl_cmsb)
   );

   // Select the operand chunk addressed by the slice counter.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt_q == CW'(i)) begin
            sl_a = a_q[i*CHUNK +: CHUNK];
            sl_b = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               // Subtraction as a + ~b + 1: invert b here, force carry-in.
               b_d     = b ^ {WIDTH{sub}};
               carry_d = (sub == MODE_SUB) ? 1'b1 : cin;
               cnt_d   = '0;
               sum_d   = '0;
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            for (int i = 0; i < NSLICE; i++) begin
               if (cnt_q == CW'(i)) begin
                  sum_d[i*CHUNK +: CHUNK] = sl_s;
               end
            end
            carry_d = sl_co;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               cout_d  = sl_co;
               ovf_d   = sl_cmsb ^ sl_co;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule : seq_slice_adder
`default_nettype wire
